// File: rtl/ds2411_responder_if.sv
// Pad and status bundle between a 1-Wire master (or bench) and the DS2411 responder.
// The responder takes the slave modport; dq_oe is the open-drain pull-down request.
interface ds2411_responder_if;
   logic        dq_in;
   logic        dq_oe;
   logic [63:0] rom_id;
   logic [7:0]  cmd_byte;
   logic        cmd_vld;
   logic        bad_cmd;
   logic        busy;

   modport master (
      output dq_in,
      output rom_id,
      input  dq_oe,
      input  cmd_byte,
      input  cmd_vld,
      input  bad_cmd,
      input  busy
   );

   modport slave (
      input  dq_in,
      input  rom_id,
      output dq_oe,
      output cmd_byte,
      output cmd_vld,
      output bad_cmd,
      output busy
   );
endinterface

// File: rtl/ds2411_responder.sv
// 1-Wire slave emulating a DS2411: presence on line reset, command receive, READ ROM (0x33) reply.
// Optional DS2411_CRC_CHECK_EN: suppress presence when rom_id[63:56] is not the CRC-8 of rom_id[55:0].
module ds2411_responder #(
   parameter int unsigned CLK_MHZ      = 100,
   parameter int unsigned RESET_MIN_US = 480,
   parameter int unsigned PRES_WAIT_US = 30,
   parameter int unsigned PRES_US      = 120,
   parameter int unsigned SAMPLE_US    = 30,
   parameter int unsigned HOLD0_US     = 45
) (
   input logic               clk_i,
   input logic               reset_ni,
   ds2411_responder_if.slave bus_io
);

   localparam int unsigned PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam int unsigned LW = $clog2(RESET_MIN_US + 1);
   localparam int unsigned TW = 10;
   localparam logic [7:0]  ReadRomCmd = 8'h33;

   typedef enum logic [2:0] {
      StIdle,
      StPresWait,
      StPres,
      StCmdRx,
      StRomTx
   } state_e;

   state_e        state_q;
   logic          dq_meta_q, dq_s_q, dq_prev_q;
   logic [PW-1:0] pre_q;
   logic [TW-1:0] tmr_q;
   logic [LW-1:0] low_us_q;
   logic          arm_q;
   logic          slot_open_q;
   logic [5:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          dq_oe_q;
   logic [7:0]    cmd_byte_q;
   logic          cmd_vld_q;
   logic          bad_cmd_q;
   logic          busy_q;

   logic          dq_fall, dq_rise, us_tick, slot_fall, line_rst, rom_bit;
   logic [7:0]    shift_nxt;

`ifdef DS2411_CRC_CHECK_EN
   logic crc_ok_q;
   logic crc_ok;

   // CRC-8 Maxim (reflected poly 0x8C), data consumed LSB first.
   function automatic logic [7:0] crc8_maxim(input logic [55:0] data);
      logic [7:0] crc;
      crc = 8'h00;
      for (int i = 0; i < 56; i++) begin
         if (crc[0] ^ data[i]) crc = (crc >> 1) ^ 8'h8C;
         else                  crc = crc >> 1;
      end
      return crc;
   endfunction

   assign crc_ok = (crc8_maxim(bus_io.rom_id[55:0]) == bus_io.rom_id[63:56]);
`endif

   assign dq_fall   = dq_prev_q & ~dq_s_q;
   assign dq_rise   = ~dq_prev_q & dq_s_q;
   assign us_tick   = (pre_q == PW'(CLK_MHZ - 1));
   // Our own pull-down also produces a falling edge; only master-driven edges open slots.
   assign slot_fall = dq_fall & arm_q & ~dq_oe_q;
   assign line_rst  = dq_rise & (low_us_q >= LW'(RESET_MIN_US));
   assign rom_bit   = bus_io.rom_id[bit_idx_q];
   assign shift_nxt = {dq_s_q, shift_q[7:1]};

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         dq_meta_q   <= 1'b1;
         dq_s_q      <= 1'b1;
         dq_prev_q   <= 1'b1;
         pre_q       <= '0;
         tmr_q       <= '0;
         low_us_q    <= '0;
         arm_q       <= 1'b1;
         slot_open_q <= 1'b0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         dq_oe_q     <= 1'b0;
         cmd_byte_q  <= '0;
         cmd_vld_q   <= 1'b0;
         bad_cmd_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef DS2411_CRC_CHECK_EN
         crc_ok_q    <= 1'b0;
`endif
      end else begin
         dq_meta_q <= bus_io.dq_in;
         dq_s_q    <= dq_meta_q;
         dq_prev_q <= dq_s_q;
         cmd_vld_q <= 1'b0;
         bad_cmd_q <= 1'b0;

         if (dq_fall || us_tick) pre_q <= '0;
         else                    pre_q <= pre_q + 1'b1;

         if (us_tick && (tmr_q != '1)) tmr_q <= tmr_q + 1'b1;

         if (dq_s_q) begin
            low_us_q <= '0;
         end else if (us_tick && !dq_oe_q && (low_us_q < LW'(RESET_MIN_US))) begin
            low_us_q <= low_us_q + 1'b1;
         end

         if (dq_oe_q)     arm_q <= 1'b0;
         else if (dq_s_q) arm_q <= 1'b1;

         // Line reset takes priority over anything the current state would do this cycle.
         if (line_rst) begin
            state_q     <= StPresWait;
            bit_idx_q   <= '0;
            dq_oe_q     <= 1'b0;
            slot_open_q <= 1'b0;
            tmr_q       <= '0;
            pre_q       <= '0;
`ifdef DS2411_CRC_CHECK_EN
            crc_ok_q    <= crc_ok;
`endif
         end else begin
            unique case (state_q)
               StIdle: begin
                  busy_q <= 1'b0;
               end

               StPresWait: begin
                  if (tmr_q == TW'(PRES_WAIT_US)) begin
`ifdef DS2411_CRC_CHECK_EN
                     if (crc_ok_q) begin
                        state_q <= StPres;
                        dq_oe_q <= 1'b1;
                        busy_q  <= 1'b1;
                     end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end
`else
                     state_q <= StPres;
                     dq_oe_q <= 1'b1;
                     busy_q  <= 1'b1;
`endif
                     tmr_q <= '0;
                     pre_q <= '0;
                  end
               end

               StPres: begin
                  if (tmr_q == TW'(PRES_US)) begin
                     dq_oe_q     <= 1'b0;
                     state_q     <= StCmdRx;
                     bit_idx_q   <= '0;
                     slot_open_q <= 1'b0;
                  end
               end

               StCmdRx: begin
                  // A new slot edge before the sample point simply restarts the slot.
                  if (slot_fall) begin
                     tmr_q       <= '0;
                     slot_open_q <= 1'b1;
                  end else if (slot_open_q && (tmr_q == TW'(SAMPLE_US))) begin
                     slot_open_q <= 1'b0;
                     shift_q     <= shift_nxt;
                     if (bit_idx_q[2:0] == 3'd7) begin
                        bit_idx_q  <= '0;
                        cmd_byte_q <= shift_nxt;
                        cmd_vld_q  <= 1'b1;
                        if (shift_nxt == ReadRomCmd) begin
                           state_q <= StRomTx;
                        end else begin
                           bad_cmd_q <= 1'b1;
                           state_q   <= StIdle;
                           busy_q    <= 1'b0;
                        end
                     end else begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                     end
                  end
               end

               StRomTx: begin
                  if (slot_fall) begin
                     slot_open_q <= 1'b1;
                     tmr_q       <= '0;
                     if (!rom_bit) dq_oe_q <= 1'b1;
                  end else if (slot_open_q) begin
                     if (dq_oe_q) begin
                        if (tmr_q == TW'(HOLD0_US)) dq_oe_q <= 1'b0;
                     end else if (dq_s_q) begin
                        slot_open_q <= 1'b0;
                        if (bit_idx_q == 6'd63) begin
                           bit_idx_q <= '0;
                           state_q   <= StIdle;
                           busy_q    <= 1'b0;
                        end else begin
                           bit_idx_q <= bit_idx_q + 1'b1;
                        end
                     end
                  end
               end

               default: begin
                  state_q <= StIdle;
                  dq_oe_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus_io.dq_oe    = dq_oe_q;
   assign bus_io.cmd_byte = cmd_byte_q;
   assign bus_io.cmd_vld  = cmd_vld_q;
   assign bus_io.bad_cmd  = bad_cmd_q;
   assign bus_io.busy     = busy_q;

endmodule
